// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// glitch-free step retuning on carry boundaries, and a settle counter driving `locked`.
module clk_en_gen_ch #(
    parameter int               ACC_W    = 24,
    parameter logic [ACC_W-1:0] STEP_RST = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [ACC_W-1:0] i_wdata,
    output logic             o_ce,
    output logic             o_ack,
    output logic             o_apply,
    output logic             o_step_zero
);
    logic [ACC_W-1:0] r_acc, r_step, r_pend;
    logic             r_pend_v, r_ce, r_ack;
    logic [ACC_W:0]   w_sum;
    logic             w_carry, w_apply;

    assign w_sum       = {1'b0, r_acc} + {1'b0, r_step};
    assign w_carry     = w_sum[ACC_W];
    assign o_step_zero = (r_step == '0);
    // Retune only at a phase wrap (or when idle) so the output never sees a runt period.
    assign w_apply     = i_sync ? (r_pend_v | i_wr)
                                : (r_pend_v & (w_carry | o_step_zero));
    assign o_apply     = w_apply;
    assign o_ce        = r_ce;
    assign o_ack       = r_ack;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_step   <= STEP_RST;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_ce     <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (i_sync) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_carry;
            end
            if (i_sync && i_wr) begin
                r_step   <= i_wdata;
                r_pend_v <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_step   <= r_pend;
                    r_pend_v <= 1'b0;
                end
                // A write landing on an application edge stays pending for the next wrap.
                if (i_wr) begin
                    r_pend   <= i_wdata;
                    r_pend_v <= 1'b1;
                end
            end
        end
    end
endmodule

module clk_en_gen #(
    parameter int                     NCH       = 3,
    parameter int                     ACC_W     = 24,
    parameter int                     LOCK_CYC  = 16,
    parameter logic [NCH*ACC_W-1:0]   STEP_INIT = '0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [ACC_W-1:0] cfg_step,
    output logic [NCH-1:0]   cfg_ack,
    output logic [NCH-1:0]   ce,
    output logic             locked
);
    logic [NCH-1:0] w_apply, w_step_zero;
    logic [7:0]     r_cnt;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic w_wr;
        // Channel numbers >= NCH never match, so such writes fall away.
        assign w_wr = cfg_we && (cfg_ch == 3'(i));
        clk_en_gen_ch #(
            .ACC_W   (ACC_W),
            .STEP_RST(STEP_INIT[i*ACC_W +: ACC_W])
        ) u_ch (
            .i_clk      (refclk),
            .i_rst_n    (rst_n),
            .i_sync     (sync),
            .i_wr       (w_wr),
            .i_wdata    (cfg_step),
            .o_ce       (ce[i]),
            .o_ack      (cfg_ack[i]),
            .o_apply    (w_apply[i]),
            .o_step_zero(w_step_zero[i])
        );
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (sync || (|w_apply))
            r_cnt <= '0;
        else if (r_cnt != 8'(LOCK_CYC))
            r_cnt <= r_cnt + 8'd1;
    end

    assign locked = (r_cnt == 8'(LOCK_CYC)) && !(|w_step_zero);
endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter NCH, default 3: number of clock-enable channels, legal 1..8.
REQ-002 SHALL have parameter ACC_W, default 24: phase-accumulator and step width, legal 4..32.
REQ-003 SHALL have parameter LOCK_CYC, default 16: settle cycles before locked asserts, legal 1..255.
REQ-004 SHALL have parameter STEP_INIT, width NCH*ACC_W, default all zero: per-channel reset step, channel i in bits [i*ACC_W +: ACC_W].
REQ-005 SHALL have port refclk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sync, input, 1 bit: phase restart of all channels.
REQ-008 SHALL have port cfg_we, input, 1 bit: step write strobe.
REQ-009 SHALL have port cfg_ch, input, 3 bits: target channel.
REQ-010 SHALL have port cfg_step, input, ACC_W bits: new step value.
REQ-011 SHALL have port cfg_ack, output, NCH bits: one-cycle pulse per channel when a step is applied.
REQ-012 SHALL have port ce, output, NCH bits: one-cycle clock-enable pulses.
REQ-013 SHALL have port locked, output, 1 bit: all channels settled.

Function
REQ-014 Each channel i SHALL hold an ACC_W-bit accumulator acc[i] and an active step step[i]; every cycle acc[i] <= (acc[i] + step[i]) mod 2^ACC_W.
REQ-015 ce[i] SHALL be registered: high exactly in the cycle after an add that produces a carry out of bit ACC_W-1, otherwise low; average rate = f_refclk*step/2^ACC_W.
REQ-016 step[i] = 0 SHALL hold ce[i] permanently low.
REQ-017 cfg_we with cfg_ch < NCH SHALL load pending[cfg_ch] <= cfg_step and set pend_v[cfg_ch]; cfg_ch >= NCH SHALL be ignored with no state change.
REQ-018 A second write to a channel with pend_v set SHALL overwrite pending; only the last value SHALL be applied, with a single cfg_ack.
REQ-019 A pending step SHALL be applied (step <= pending, pend_v cleared) in the cycle whose add produces a carry, or on the next edge when the current step is 0; the accumulator SHALL keep its wrapped value, so there is no runt or double ce.
REQ-020 cfg_ack[i] SHALL pulse high for exactly one cycle, the cycle after the application edge.
REQ-021 A cfg_we to channel i in the same cycle as application of channel i's older pending value SHALL apply the older value and leave the new value pending.
REQ-022 sync high SHALL, on that edge, clear every acc to 0, force ce to 0, and apply every pending step immediately with cfg_ack pulses; a same-cycle cfg_we SHALL also apply immediately.
REQ-023 sync held high SHALL keep acc at 0 and ce at 0; counting SHALL resume on the first edge with sync low.
REQ-024 locked SHALL be driven by a saturating settle counter that restarts at 0 on reset, on any sync cycle, and on any step application; locked SHALL be 1 only when the counter equals LOCK_CYC and no channel has step 0.
REQ-025 Widths SHALL be exact: no truncation of step; the carry SHALL be taken from an ACC_W+1-bit sum.

Reset
REQ-026 rst_n low SHALL asynchronously set acc = 0, step = STEP_INIT, pend_v = 0, ce = 0, cfg_ack = 0, locked = 0, and the settle counter to 0.
REQ-027 Release SHALL be synchronous to refclk; the first add SHALL occur on the first edge with rst_n high.
REQ-028 Reset asserted mid-operation SHALL discard pending writes and SHALL NOT emit a cfg_ack.

Verification
REQ-029 ACC_W=4, STEP_INIT ch0=4, release reset -> ce[0] high after edges 4, 8, 12, ...; exactly one-cycle pulses.
REQ-030 ACC_W=4, ch0 step 6 -> exactly 6 ce pulses per 16 cycles, none adjacent; step 0 -> no ce over 100 cycles.
REQ-031 ch0 step 4; write ch0=8 mid-period -> applied on next carry edge; cfg_ack[0] one cycle later; afterwards ce every 2 cycles; no extra pulse in the transition.
REQ-032 Two writes ch1=3 then ch1=5 before a carry -> single cfg_ack[1]; final rate 5/16; cfg_ch=7 with NCH=3 -> no state change.
REQ-033 LOCK_CYC=16, all steps nonzero -> locked rises 16 cycles after reset release; sync pulse -> locked low, acc=0, ce low, relock after 16 cycles.
REQ-034 ACC_W=24, step 8053063 (50 MHz -> 24 MHz) -> ce count over 10^6 cycles within +/-1 of 480000; rst_n low mid-run -> all outputs 0 immediately.
